// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Holds the default word width and memory depth, and the loader FSM state encodings.
// The checksum phase state (StChk) is only reached when LOADER_CHECKSUM_EN is defined.
package instr_mem_loader_pkg;

  localparam int unsigned DataWidthDef = 32;
  localparam int unsigned RomDepthDef  = 16;
  localparam int unsigned LenWidth     = 16;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenLo = 3'd1;
  localparam logic [2:0] StLenHi = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StChk   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  // States in which a load is in flight and stream bytes are accepted.
  function automatic logic is_busy(logic [2:0] st);
    return st inside {StLenLo, StLenHi, StData, StChk};
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Byte-to-word packer for the instruction memory loader.
// Shifts accepted bytes in little-endian order (first byte ends up in bits [7:0]) and emits a
// one-cycle word_valid pulse with the completed word on the cycle after its last byte.
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  clear       restart packing from byte 0 (new load)
//  byte_en     a stream byte is accepted this cycle
//  byte_in     the accepted byte
//  last_byte   the next accepted byte completes a word
//  word_valid  completed word available (1-cycle pulse)
//  word        completed word, held until the next word completes
module instr_mem_loader_byte_word_packer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic                  last_byte,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int unsigned BytesPerWord = DATA_WIDTH / 8;
  localparam int unsigned CntWidth     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

  logic [CntWidth-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  valid_q;

  // New byte enters at the top; after a full word the first byte has reached bits [7:0].
  assign shift_in  = (shift_q >> 8) | (DATA_WIDTH'(byte_in) << (DATA_WIDTH - 8));
  assign last_byte = (cnt_q == CntWidth'(BytesPerWord - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (byte_en) begin
        shift_q <= shift_in;
        if (last_byte) begin
          cnt_q   <= '0;
          word_q  <= shift_in;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign word_valid = valid_q;
  assign word       = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time program writer for the SoC instruction memory.
// Receives a byte stream: 16-bit word count LEN (low byte first), then LEN words of
// DATA_WIDTH/8 little-endian bytes each. Words are written to consecutive addresses from 0.
// rv_core is held in reset (core_rstn_o=0) until a load completes successfully.
// Optional feature (macro LOADER_CHECKSUM_EN): one trailing byte must equal the XOR of all
// data bytes, otherwise the load ends in error.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  load_start_i             1-cycle request to begin a load (ignored while busy)
//  byte_valid_i/byte_i      stream byte; accepted when byte_ready_o is also high
//  byte_ready_o             loader can accept a byte
//  mem_we_o/addr/wdata      instruction memory write port, 1-cycle strobe per word
//  core_rstn_o              active-low core reset, released only in DONE
//  busy_o, done_o, err_o    load status
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned ROM_DEPTH  = RomDepthDef,
  parameter int unsigned ADDR_WIDTH = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  core_rstn_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  logic [2:0]          state_q, state_d;
  logic [7:0]          len_lo_q;
  logic [LenWidth-1:0] len_q;
  logic [LenWidth-1:0] len_full;
  logic [LenWidth-1:0] words_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                accept;
  logic                data_byte;
  logic                start_ok;
  logic                last_byte;
  logic                last_word_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_q;
`endif

  assign accept    = byte_valid_i & byte_ready_o;
  assign data_byte = accept & (state_q == StData);
  assign start_ok  = load_start_i & ~is_busy(state_q);
  assign len_full  = {byte_i, len_lo_q};
  // words_q counts words already packed, so len_q-1 identifies the final word's last byte.
  assign last_word_byte = data_byte & last_byte & (words_q == len_q - 1'b1);

  instr_mem_loader_byte_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_en    (data_byte),
    .byte_in    (byte_i),
    .last_byte  (last_byte),
    .word_valid (mem_we_o),
    .word       (mem_wdata_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (load_start_i) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) begin
          if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else if ({1'b0, len_full} > 17'(ROM_DEPTH)) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (last_word_byte) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) state_d = (byte_i == chk_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_lo_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_lo_q <= '0;
        len_q    <= '0;
        words_q  <= '0;
        addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
        chk_q    <= '0;
`endif
      end
      if (accept && state_q == StLenLo) len_lo_q <= byte_i;
      if (accept && state_q == StLenHi) len_q <= len_full;
      // Address is latched with the last byte so it lines up with the packer's write pulse.
      if (data_byte && last_byte) begin
        addr_q  <= words_q[ADDR_WIDTH-1:0];
        words_q <= words_q + 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (data_byte) chk_q <= chk_q ^ byte_i;
`endif
    end
  end

  assign mem_addr_o   = addr_q;
  assign byte_ready_o = is_busy(state_q);
  assign busy_o       = is_busy(state_q);
  assign done_o       = (state_q == StDone);
  assign err_o        = (state_q == StErr);
  assign core_rstn_o  = (state_q == StDone);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BPW   = DW / 8;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start_i = 1'b0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          core_rstn_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic          we_prev = 1'b0;
  logic          we_long = 1'b0;

  instr_mem_loader #(
    .DATA_WIDTH (DW),
    .ROM_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rstn_o  (core_rstn_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: records every write, flags any strobe wider than one cycle.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_wdata_o);
      if (we_prev) we_long <= 1'b1;
    end
    we_prev <= (mem_we_o === 1'b1);
  end

  // Reference: word i is bytes [i*BPW .. i*BPW+BPW-1], first byte least significant.
  function automatic logic [DW-1:0] model_word(bq_t data, int idx);
    logic [DW-1:0] w = '0;
    for (int k = 0; k < int'(BPW); k++) w = w + (DW'(data[idx*BPW + k]) << (8 * k));
    return w;
  endfunction

  function automatic logic [7:0] model_xor(bq_t data);
    logic [7:0] x = 8'h00;
    foreach (data[i]) x = x ^ data[i];
    return x;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
  endtask

  // Offers one byte after 0..max_gap idle cycles and holds it until accepted (bounded).
  task automatic drive_byte(input logic [7:0] b, input int max_gap);
    bit ok = 0;
    bit rdy;
    byte_valid_i = 1'b0;
    repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    byte_valid_i = 1'b1;
    byte_i = b;
    for (int n = 0; n < 50; n++) begin
      rdy = byte_ready_o;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    byte_valid_i = 1'b0;
    byte_i = 8'($urandom);
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept_timeout: byte %02h not accepted, required acceptance", b);
    end
  endtask

  task automatic send_len(input int len, input int max_gap);
    logic [15:0] l = 16'(len);
    drive_byte(l[7:0], max_gap);
    drive_byte(l[15:8], max_gap);
  endtask

  task automatic send_data(input bq_t data, input int max_gap);
    foreach (data[i]) drive_byte(data[i], max_gap);
  endtask

  task automatic send_chk(input bq_t data, input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
    drive_byte(model_xor(data) ^ (corrupt ? 8'h01 : 8'h00), 1);
`endif
  endtask

  // Waits (bounded) for done/err, then one more cycle so the final write is logged.
  task automatic wait_end(input string name);
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (done_o || err_o) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_end_timeout: done/err never rose, required within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    byte_valid_i = 1'b1;
    byte_i = 8'hA5;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({byte_ready_o, mem_we_o, busy_o, done_o, err_o, core_rstn_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %06b required 000000",
               {byte_ready_o, mem_we_o, busy_o, done_o, err_o, core_rstn_o});
    end
    checks++;
    if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_mem: addr %0h data %0h required 0/0", mem_addr_o, mem_wdata_o);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_not_ready: ready %b busy %b required 0/0", byte_ready_o, busy_o);
      end
    end
    byte_valid_i = 1'b0;
    checks++;
    if (wr_data.size() != 0) begin
      errors++;
      $display("FAIL reset_no_write: got %0d writes required 0", wr_data.size());
    end
  endtask

  task automatic test_known_load();
    bq_t data = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    start_load();
    checks++;
    if (busy_o !== 1'b1 || core_rstn_o !== 1'b0) begin
      errors++;
      $display("FAIL known_busy: busy %b rstn %b required 1/0", busy_o, core_rstn_o);
    end
    send_len(2, 0);
    send_data(data, 0);
    send_chk(data, 0);
    wait_end("known");
    checks++;
    if (wr_data.size() != 2) begin
      errors++;
      $display("FAIL known_wr_count: got %0d required 2", wr_data.size());
    end else begin
      checks++;
      if (wr_addr[0] !== AW'(0) || wr_data[0] !== 32'h0000_0013) begin
        errors++;
        $display("FAIL known_wr0: got (%0d,%08h) required (0,00000013)", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== AW'(1) || wr_data[1] !== 32'h0010_0093) begin
        errors++;
        $display("FAIL known_wr1: got (%0d,%08h) required (1,00100093)", wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if ({done_o, err_o, core_rstn_o, busy_o} !== 4'b1010) begin
      errors++;
      $display("FAIL known_status: done/err/rstn/busy %04b required 1010",
               {done_o, err_o, core_rstn_o, busy_o});
    end
  endtask

  task automatic test_len_zero();
    bq_t none = {};
    clear_log();
    start_load();
    checks++;
    if (done_o !== 1'b0 || core_rstn_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: done %b rstn %b busy %b required 0/0/1",
               done_o, core_rstn_o, busy_o);
    end
    send_len(0, 1);
    send_chk(none, 0);
    wait_end("len0");
    checks++;
    if (wr_data.size() != 0 || done_o !== 1'b1 || core_rstn_o !== 1'b1) begin
      errors++;
      $display("FAIL len0: writes %0d done %b rstn %b required 0/1/1",
               wr_data.size(), done_o, core_rstn_o);
    end
  endtask

  task automatic test_len_overflow();
    clear_log();
    start_load();
    send_len(DEPTH + 1, 1);
    wait_end("ovf");
    checks++;
    if ({done_o, err_o, core_rstn_o, busy_o} !== 4'b0100 || wr_data.size() != 0) begin
      errors++;
      $display("FAIL len_overflow: done/err/rstn/busy %04b writes %0d required 0100 and 0",
               {done_o, err_o, core_rstn_o, busy_o}, wr_data.size());
    end
    byte_valid_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL err_not_ready: ready %b required 0", byte_ready_o);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_random_valid();
    for (int it = 0; it < 6; it++) begin
      int len = (it == 0) ? int'(DEPTH) : int'($urandom_range(DEPTH, 1));
      bq_t data = {};
      for (int i = 0; i < len * int'(BPW); i++) data.push_back(8'($urandom));
      clear_log();
      start_load();
      send_len(len, 2);
      for (int i = 0; i < data.size(); i++) begin
        // A start request mid-load must be ignored.
        if (it == 1 && i == 5) start_load();
        drive_byte(data[i], (it == 2) ? 0 : 3);
      end
      send_chk(data, 0);
      wait_end("rand");
      checks++;
      if (wr_data.size() != len) begin
        errors++;
        $display("FAIL rand_wr_count it%0d: got %0d required %0d", it, wr_data.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (wr_addr[i] !== AW'(i) || wr_data[i] !== model_word(data, i)) begin
            errors++;
            $display("FAIL rand_wr it%0d #%0d: got (%0d,%08h) required (%0d,%08h)",
                     it, i, wr_addr[i], wr_data[i], i, model_word(data, i));
          end
        end
      end
      checks++;
      if (done_o !== 1'b1 || core_rstn_o !== 1'b1) begin
        errors++;
        $display("FAIL rand_done it%0d: done %b rstn %b required 1/1", it, done_o, core_rstn_o);
      end
    end
    checks++;
    if (we_long !== 1'b0) begin
      errors++;
      $display("FAIL we_width: strobe held %b required single-cycle", we_long);
    end
  endtask

  task automatic test_mid_reset();
    bq_t first = '{8'h11, 8'h22, 8'h33, 8'h44};
    bq_t data = {};
    for (int i = 0; i < int'(BPW); i++) data.push_back(8'($urandom));
    start_load();
    send_len(2, 0);
    send_data(first, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    checks++;
    if ({byte_ready_o, mem_we_o, busy_o, done_o, err_o, core_rstn_o} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_idle: flags %06b required 000000",
               {byte_ready_o, mem_we_o, busy_o, done_o, err_o, core_rstn_o});
    end
    start_load();
    send_len(1, 1);
    send_data(data, 1);
    send_chk(data, 0);
    wait_end("midreset");
    checks++;
    if (wr_data.size() != 1 || wr_addr[0] !== AW'(0) || wr_data[0] !== model_word(data, 0)) begin
      errors++;
      $display("FAIL midreset_reload: writes %0d first (%0d,%08h) required 1 (0,%08h)",
               wr_data.size(), (wr_addr.size() > 0) ? wr_addr[0] : '0,
               (wr_data.size() > 0) ? wr_data[0] : '0, model_word(data, 0));
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t data = '{8'h13, 8'h00, 8'h00, 8'h00};
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      start_load();
      send_len(1, 0);
      send_data(data, 0);
      drive_byte((pass == 0) ? 8'h13 : 8'h12, 0);
      wait_end("chk");
      checks++;
      if (wr_data.size() != 1 || wr_data[0] !== 32'h0000_0013) begin
        errors++;
        $display("FAIL chk_write pass%0d: writes %0d required 1 of 00000013", pass,
                 wr_data.size());
      end
      checks++;
      if ({done_o, err_o, core_rstn_o} !== ((pass == 0) ? 3'b101 : 3'b010)) begin
        errors++;
        $display("FAIL chk_status pass%0d: done/err/rstn %03b required %03b", pass,
                 {done_o, err_o, core_rstn_o}, (pass == 0) ? 3'b101 : 3'b010);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_load();
    test_len_zero();
    test_len_overflow();
    test_random_valid();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
